// File: rtl/power_sequencer.sv
// Clock-enable sequencer for the gated compute domain: warmup, idle hysteresis,
// wake latency, client ready indication and a saturating gated-cycle counter.
module power_sequencer #(
    parameter int NREQ       = 4,
    parameter int WARMUP_CYC = 4,
    parameter int IDLE_HYST  = 8,
    parameter int WAKE_CYC   = 2,
    parameter int TMR_W      = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             predict,
    input  logic [NREQ-1:0]  req,
    input  logic             force_on,
    input  logic             stats_clr,
    output logic             clk_en,
    output logic             ready,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] gated_cnt
);

    typedef enum logic [2:0] {
        ST_WARMUP = 3'd0,
        ST_ON     = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_OFF    = 3'd3,
        ST_WAKE   = 3'd4
    } state_e;

    localparam logic [TMR_W-1:0] WARMUP_LAST = TMR_W'(WARMUP_CYC - 1);
    localparam logic [TMR_W-1:0] HYST_LAST   = TMR_W'(IDLE_HYST - 1);
    localparam logic [TMR_W-1:0] WAKE_LAST   = TMR_W'(WAKE_CYC - 1);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wake;

    assign wake = predict || (|req) || force_on;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            ST_WARMUP: begin
                if (timer_q == WARMUP_LAST) begin
                    state_d = ST_ON;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_ON: begin
                if (!wake) begin
                    state_d = ST_DRAIN;
                    timer_d = '0;
                end
            end
            ST_DRAIN: begin
                // Any non-idle cycle restarts the whole hysteresis window.
                if (wake) begin
                    state_d = ST_ON;
                    timer_d = '0;
                end else if (timer_q == HYST_LAST) begin
                    state_d = ST_OFF;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_OFF: begin
                if (wake) begin
                    state_d = ST_WAKE;
                    timer_d = '0;
                end
            end
            ST_WAKE: begin
                if (timer_q == WAKE_LAST) begin
                    state_d = ST_ON;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_WARMUP;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stats_clr) begin
            cnt_d = '0;
        end else if ((state_q == ST_OFF) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_WARMUP;
            timer_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clk_en    = (state_q != ST_OFF);
    assign ready     = (state_q == ST_ON) || (state_q == ST_DRAIN);
    assign state     = state_q;
    assign gated_cnt = cnt_q;

endmodule

// File: tb/tb_power_sequencer.sv
// Directed bench for power_sequencer; expected outcomes queued per step and
// compared after each clock edge (16-bit and 4-bit counter instances share inputs).
module tb_power_sequencer;

    localparam logic [2:0] S_WARMUP = 3'd0;
    localparam logic [2:0] S_ON     = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_OFF    = 3'd3;
    localparam logic [2:0] S_WAKE   = 3'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic        predict;
    logic [3:0]  req;
    logic        force_on;
    logic        stats_clr;
    logic        clk_en, ready, clk_en4, ready4;
    logic [2:0]  state, state4;
    logic [15:0] gated_cnt;
    logic [3:0]  gated_cnt4;

    typedef struct {
        logic [2:0]  st;
        logic        ce;
        logic        rdy;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    power_sequencer dut (
        .clk(clk), .reset(reset), .predict(predict), .req(req),
        .force_on(force_on), .stats_clr(stats_clr),
        .clk_en(clk_en), .ready(ready), .state(state), .gated_cnt(gated_cnt)
    );

    power_sequencer #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .predict(predict), .req(req),
        .force_on(force_on), .stats_clr(stats_clr),
        .clk_en(clk_en4), .ready(ready4), .state(state4), .gated_cnt(gated_cnt4)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic push(input logic [2:0] st, input int cnt, input int cnt4);
        exp_t e;
        e.st   = st;
        e.ce   = (st != S_OFF);
        e.rdy  = (st == S_ON) || (st == S_DRAIN);
        e.cnt  = 16'(cnt);
        e.cnt4 = 4'(cnt4);
        sb.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 16'd1, 16'd0);
        end else begin
            e = sb.pop_front();
            chk("state",      state,      e.st);
            chk("clk_en",     clk_en,     e.ce);
            chk("ready",      ready,      e.rdy);
            chk("gated_cnt",  gated_cnt,  e.cnt);
            chk("state_c4",   state4,     e.st);
            chk("gated_cnt4", gated_cnt4, e.cnt4);
        end
    endtask

    task automatic step(input logic [2:0] st, input int cnt, input int cnt4);
        push(st, cnt, cnt4);
        @(posedge clk);
        #1;
        pop_compare();
    endtask

    task automatic expect_now(input logic [2:0] st, input int cnt, input int cnt4);
        push(st, cnt, cnt4);
        pop_compare();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        predict   = 1'b0;
        req       = '0;
        force_on  = 1'b0;
        stats_clr = 1'b0;
        #2;
        expect_now(S_WARMUP, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Warmup for 4 edges, then idle drains to OFF at edge 13.
        for (int i = 1; i <= 3; i++) step(S_WARMUP, 0, 0);
        step(S_ON, 0, 0);
        step(S_DRAIN, 0, 0);
        for (int i = 6; i <= 12; i++) step(S_DRAIN, 0, 0);
        step(S_OFF, 0, 0);

        // Gated cycles counted; 4-bit counter saturates at 15.
        for (int i = 1; i <= 19; i++) step(S_OFF, i, (i > 15) ? 15 : i);
        predict = 1'b1;
        step(S_WAKE, 20, 15);
        predict = 1'b0;
        step(S_WAKE, 20, 15);
        step(S_ON, 20, 15);

        // One-cycle req pulse at DRAIN timer=5 restarts the full hysteresis.
        step(S_DRAIN, 20, 15);
        for (int i = 1; i <= 5; i++) step(S_DRAIN, 20, 15);
        req = 4'b0100;
        step(S_ON, 20, 15);
        req = '0;
        for (int i = 1; i <= 8; i++) step(S_DRAIN, 20, 15);
        step(S_OFF, 20, 15);

        // stats_clr in OFF wins over the increment.
        for (int i = 21; i <= 23; i++) step(S_OFF, i, 15);
        stats_clr = 1'b1;
        step(S_OFF, 0, 0);
        stats_clr = 1'b0;
        for (int i = 1; i <= 3; i++) step(S_OFF, i, i);

        // Asynchronous reset between edges while OFF.
        #3;
        reset = 1'b1;
        #1;
        expect_now(S_WARMUP, 0, 0);
        force_on = 1'b1;
        @(posedge clk);
        #1;
        expect_now(S_WARMUP, 0, 0);
        reset = 1'b0;

        // force_on keeps the domain in ON indefinitely.
        for (int i = 1; i <= 3; i++) step(S_WARMUP, 0, 0);
        step(S_ON, 0, 0);
        for (int i = 1; i <= 100; i++) step(S_ON, 0, 0);

        // force_on during DRAIN returns to ON.
        force_on = 1'b0;
        step(S_DRAIN, 0, 0);
        step(S_DRAIN, 0, 0);
        force_on = 1'b1;
        step(S_ON, 0, 0);
        force_on = 1'b0;
        step(S_DRAIN, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/power_sequencer.md
Name: power_sequencer

Overview:
- Moore-style sequencer for the clock-gated compute domain.
- Merges the ML `predict` hint, datapath client requests and a software force-on into one registered clock enable, `clk_en`. `clk_en` feeds the clock-gate cell.
- Adds warmup, idle hysteresis and wake latency so the gate never toggles cycle-to-cycle. Also tells clients when the domain is usable, and counts gated cycles for power telemetry.

Parameters:
- NREQ, 4, number of client request lines.
- WARMUP_CYC, 4, cycles forced on after reset (>=1).
- IDLE_HYST, 8, consecutive idle cycles in DRAIN before gating (>=1).
- WAKE_CYC, 2, cycles clock runs before clients are told ready (>=1).
- TMR_W, 8, internal timer width; every *_CYC/HYST value must be < 2^TMR_W.
- CNT_W, 16, gated-cycle counter width.

Ports:
- clk  in  1  system clock (ungated).
- reset  in  1  asynchronous, active-high reset.
- predict  in  1  ML hint; 1 = domain will be needed soon.
- req  in  NREQ  per-client "need domain" level signals.
- force_on  in  1  software override; keeps domain on.
- stats_clr  in  1  synchronous clear of gated_cnt.
- clk_en  out  1  enable to clock gate; 1 = clock running.
- ready  out  1  domain clocked and settled; clients may issue work.
- state  out  3  current state encoding (debug).
- gated_cnt  out  CNT_W  saturating count of cycles spent in OFF.

Behaviour:
- Encodings: WARMUP=0, ON=1, DRAIN=2, OFF=3, WAKE=4. Values 5–7 are illegal and recover to WARMUP on the next edge.
- Outputs are decoded from registered state only; there is no combinational path from input to output.
  - clk_en = (state != OFF).
  - ready = (state == ON or DRAIN).
- Reset (async assert) forces: state=WARMUP, timer=0, gated_cnt=0, clk_en=1, ready=0. Reset mid-operation from any state behaves the same, including OFF, where clk_en returns to 1 immediately on assert.
- Derived terms:
  - idle = !predict && (req==0) && !force_on
  - wake = predict || |req || force_on
- WARMUP:
  - Inputs are ignored.
  - timer increments each edge.
  - When timer==WARMUP_CYC-1: go to ON and clear timer.
  - ready first goes high WARMUP_CYC edges after reset deassert.
- ON:
  - If idle: go to DRAIN with timer=0.
  - Else stay in ON.
- DRAIN:
  - If !idle: return to ON with timer=0. Any single non-idle cycle restarts the hysteresis.
  - Else if timer==IDLE_HYST-1: go to OFF.
  - Else timer++.
  - Gating therefore occurs 1+IDLE_HYST edges after idle is first sampled in ON.
- OFF:
  - gated_cnt increments each edge and saturates at all-ones without wrapping.
  - If wake: go to WAKE with timer=0.
- WAKE:
  - clk_en=1, ready=0.
  - timer increments; when timer==WAKE_CYC-1, go to ON.
  - WAKE is not abortable: if idle reasserts during WAKE, the block still goes to ON, then to DRAIN by normal rules.
- stats_clr: synchronous. If asserted in OFF it takes priority over the increment, so the count becomes 0 that edge.
- Simultaneous events:
  - In OFF, wake wins over idle trivially.
  - force_on asserted during DRAIN counts as !idle and returns to ON.
  - req changing while ready=0 is legal; clients must hold req until they see ready.
- timer is internal. It is only compared against parameters, and WARMUP/WAKE/DRAIN clear it on exit.

Test Plan:
- Reset release, all inputs 0 → clk_en=1 throughout; ready=0 for edges 1–3, ready=1 at edge 4; state WARMUP→ON at edge 4, then ON→DRAIN at edge 5, OFF at edge 13; clk_en=0 after edge 13.
- In DRAIN with timer=5, pulse req[2]=1 for one cycle → state returns to ON; with idle thereafter, OFF is reached 9 edges after the pulse clears, not earlier.
- In OFF for 20 cycles, then predict=1 for one cycle → gated_cnt=20, state WAKE next edge (clk_en=1, ready=0), ON 2 edges later with ready=1.
- force_on=1 held throughout with predict=0, req=0 for 100 cycles → state never leaves ON after warmup; gated_cnt stays 0.
- CNT_W=4, hold OFF for 20 cycles → gated_cnt saturates at 15; stats_clr pulse in OFF → gated_cnt=0 that edge, then counts 1,2,...
- Assert reset asynchronously mid-OFF (between edges) → clk_en=1, ready=0, state=0, gated_cnt=0 immediately; after release, full warmup sequence repeats.
